// File: rtl/c17_stim_pkg.sv
// Shared types and constants for the c17 pattern source.
// Holds mode/state enums, the c17 primary-input count and LFSR taps.
package c17_stim_pkg;

    localparam int C17_NUM_PI = 5;

    // x^5 + x^3 + 1 feedback mask, maximal length (period 31)
    localparam logic [C17_NUM_PI-1:0] C17_LFSR_TAPS = 5'b10100;

    typedef enum logic {
        MODE_COUNT = 1'b0,
        MODE_LFSR  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/c17_pattern_source_if.sv
// Pattern stream between the stimulus source and the c17 consumer.
// Ports: pat_out/pat_valid from master, pat_ready from slave.
interface c17_pattern_source_if #(
    parameter int WIDTH = 5
) ();

    logic [WIDTH-1:0] pat_out;
    logic             pat_valid;
    logic             pat_ready;

    modport master (
        output pat_out,
        output pat_valid,
        input  pat_ready
    );

    modport slave (
        input  pat_out,
        input  pat_valid,
        output pat_ready
    );

endinterface

// File: rtl/c17_pattern_source_lfsr.sv
// Combinational next-pattern step: binary increment or LFSR shift.
// Ports: cur (current pattern), mode, nxt (following pattern).
module pattern_lfsr
    import c17_stim_pkg::*;
#(
    parameter int               WIDTH = C17_NUM_PI,
    parameter logic [WIDTH-1:0] TAPS  = C17_LFSR_TAPS
) (
    input  logic [WIDTH-1:0] cur,
    input  mode_e            mode,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        unique case (mode)
            MODE_COUNT: nxt = cur + 1'b1;
            MODE_LFSR:  nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
        endcase
    end

endmodule

// File: rtl/c17_pattern_source.sv
// Burst pattern generator feeding the c17 primary inputs.
// Ports: clk, rst (async high), start/mode/seed/num_pats burst request,
//        pat (stream master), busy, done pulse, pat_idx accepted count.
module c17_pattern_source
    import c17_stim_pkg::*;
#(
    parameter int               WIDTH = C17_NUM_PI,
    parameter logic [WIDTH-1:0] TAPS  = C17_LFSR_TAPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [WIDTH-1:0]    seed,
    input  logic [WIDTH:0]      num_pats,
    c17_pattern_source_if.master pat,
    output logic                busy,
    output logic                done,
    output logic [WIDTH:0]      pat_idx
);

    localparam logic [WIDTH:0] PERIOD_COUNT = (WIDTH+1)'(1) << WIDTH;
    localparam logic [WIDTH:0] PERIOD_LFSR  = PERIOD_COUNT - 1'b1;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH:0]   limit_q, limit_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH:0]   idx_q, idx_d;

    logic [WIDTH-1:0] pat_nxt;
    logic [WIDTH:0]   period;
    logic [WIDTH:0]   req_limit;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH:0]   idx_inc;

    pattern_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .cur  (pat_q),
        .mode (mode_q),
        .nxt  (pat_nxt)
    );

    // Zero or oversize requests become one full period, so a burst
    // never repeats a pattern.
    always_comb begin
        period    = mode ? PERIOD_LFSR : PERIOD_COUNT;
        req_limit = num_pats;
        if (num_pats == '0 || num_pats > period) begin
            req_limit = period;
        end
        // All-zero is a lock-up state for the LFSR
        seed_eff = seed;
        if (mode && seed == '0) begin
            seed_eff = WIDTH'(1);
        end
        idx_inc = idx_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_e'(mode);
                    limit_d = req_limit;
                    pat_d   = seed_eff;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // pat_valid is high throughout RUN, so ready alone fires
                if (pat.pat_ready) begin
                    idx_d = idx_inc;
                    pat_d = pat_nxt;
                    if (idx_inc == limit_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_COUNT;
            limit_q <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
        end
    end

    assign pat.pat_out   = pat_q;
    assign pat.pat_valid = (state_q == S_RUN);
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign pat_idx       = idx_q;

endmodule

// File: tb/tb_c17_pattern_source.sv
// Self-checking bench for c17_pattern_source: table of bursts checked
// through an expected-pattern queue, plus hand-written corner sequences.
module tb_c17_pattern_source;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [4:0] seed = '0;
    logic [5:0] num_pats = '0;
    logic       busy;
    logic       done;
    logic [5:0] pat_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        logic       mode;
        logic [4:0] seed;
        logic [5:0] num;
        int         stall;
        int         exp_lim;
        logic [4:0] exp_first;
        logic [4:0] exp_last;
        logic [4:0] exp_final;
    } vec_t;

    vec_t vecs[8];

    c17_pattern_source_if #(.WIDTH(5)) pif ();

    c17_pattern_source dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .seed     (seed),
        .num_pats (num_pats),
        .pat      (pif),
        .busy     (busy),
        .done     (done),
        .pat_idx  (pat_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference step, written bitwise from x^5+x^3+1
    function automatic logic [4:0] m_next(input logic m, input logic [4:0] p);
        if (!m) return p + 5'd1;
        return {p[3:0], p[4] ^ p[2]};
    endfunction

    task automatic run_burst(input vec_t v, input int tag);
        logic [4:0] p;
        logic [4:0] e;
        logic [4:0] fin;
        bit         seen[32];
        int         fires = 0;
        int         reps = 0;
        int         cyc;
        string      t;
        t = $sformatf("v%0d", tag);
        p = (v.mode && v.seed == 5'd0) ? 5'd1 : v.seed;
        exp_q.delete();
        for (int i = 0; i < v.exp_lim; i++) begin
            exp_q.push_back(p);
            p = m_next(v.mode, p);
        end
        fin = p;
        foreach (seen[i]) seen[i] = 1'b0;
        mode = v.mode;
        seed = v.seed;
        num_pats = v.num;
        pif.pat_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({t, "_first_valid"}, pif.pat_valid, 1);
        chk({t, "_busy"}, busy, 1);
        chk({t, "_idx0"}, pat_idx, 0);
        cyc = 1;
        while (!done && cyc < 200) begin
            pif.pat_ready = (cyc > v.stall);
            if (!pif.pat_ready) begin
                chk({t, "_hold_valid"}, pif.pat_valid, 1);
                chk({t, "_hold_pat"}, pif.pat_out, exp_q[0]);
            end else if (pif.pat_valid) begin
                if (exp_q.size() == 0) begin
                    chk({t, "_extra_fire"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({t, "_pat"}, pif.pat_out, e);
                    chk({t, "_idx"}, pat_idx, fires);
                    if (fires == 0)
                        chk({t, "_first"}, pif.pat_out, v.exp_first);
                    if (exp_q.size() == 0)
                        chk({t, "_last"}, pif.pat_out, v.exp_last);
                end
                if (seen[pif.pat_out]) reps++;
                seen[pif.pat_out] = 1'b1;
                fires++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({t, "_done"}, done, 1);
        chk({t, "_done_lat"}, cyc, v.exp_lim + v.stall + 1);
        chk({t, "_fires"}, fires, v.exp_lim);
        chk({t, "_q_empty"}, exp_q.size(), 0);
        chk({t, "_no_repeat"}, reps, 0);
        chk({t, "_final_idx"}, pat_idx, v.exp_lim);
        chk({t, "_final_pat"}, pif.pat_out, v.exp_final);
        chk({t, "_final_model"}, pif.pat_out, fin);
        chk({t, "_done_valid"}, pif.pat_valid, 0);
        chk({t, "_done_busy"}, busy, 0);
        @(negedge clk);
        chk({t, "_done_1cyc"}, done, 0);
        chk({t, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        bit saw_done;
        vecs[0] = '{1'b0, 5'd0,  6'd0,  0, 32, 5'd0,  5'd31, 5'd0};
        vecs[1] = '{1'b1, 5'd1,  6'd4,  0, 4,  5'd1,  5'b01001, 5'b10010};
        vecs[2] = '{1'b1, 5'd0,  6'd0,  0, 31, 5'd1,  5'b10000, 5'd1};
        vecs[3] = '{1'b0, 5'd7,  6'd3,  3, 3,  5'd7,  5'd9,  5'd10};
        vecs[4] = '{1'b0, 5'd5,  6'd40, 0, 32, 5'd5,  5'd4,  5'd5};
        vecs[5] = '{1'b1, 5'h15, 6'd40, 0, 31, 5'h15, 5'h1A, 5'h15};
        vecs[6] = '{1'b0, 5'd30, 6'd5,  0, 5,  5'd30, 5'd2,  5'd3};
        vecs[7] = '{1'b1, 5'h1F, 6'd32, 2, 31, 5'h1F, 5'h0F, 5'h1F};

        pif.pat_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_pat", pif.pat_out, 0);
        chk("rst_valid", pif.pat_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", pat_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i], i);
        end

        // start while RUN is ignored; reset mid-burst clears at once
        mode = 1'b0;
        seed = 5'd3;
        num_pats = 6'd10;
        pif.pat_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_pat", pif.pat_out, 3 + k);
            if (k == 1) begin
                mode = 1'b1;
                seed = 5'd20;
                num_pats = 6'd2;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("t5_pat_after", pif.pat_out, 7);
        chk("t5_idx_after", pat_idx, 4);
        chk("t5_busy_after", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", pif.pat_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_idx", pat_idx, 0);
        chk("t5_rst_pat", pif.pat_out, 0);
        saw_done = done;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            saw_done |= done;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("t5_no_done", saw_done, 0);
        chk("t5_idle_busy", busy, 0);

        // start during the DONE pulse is ignored
        mode = 1'b0;
        seed = 5'd12;
        num_pats = 6'd1;
        pif.pat_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t7_pat", pif.pat_out, 12);
        @(negedge clk);
        chk("t7_done", done, 1);
        seed = 5'd0;
        num_pats = 6'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_valid", pif.pat_valid, 0);
        chk("t7_pat_hold", pif.pat_out, 13);
        chk("t7_idx_hold", pat_idx, 1);
        @(negedge clk);
        chk("t7_busy2", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
